fft_bitrev_buf: RTL and testbench
=================================

Name: fft_bitrev_buf

Overview:
- Input-side reorder buffer feeding the receiver FFT.
- Accepts one OFDM symbol of N complex samples in natural order over a valid/ready stream and stores them in internal dual-address memory.
- Streams the samples back out in bit-reversed index order with valid/ready/last.
- Single bank: it alternates strictly between FILL and DRAIN.

Parameters:
- log2N, 6, address width; N = 2**log2N.
- Q, 16, bit width of each real/imag component (two's complement, passed through untouched).
- N, 64, symbol length in samples; must equal 2**log2N.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-high reset (asserted = 1, despite the name).
- in_valid  in  1  input sample valid.
- in_ready  out  1  buffer can accept a sample.
- data_r_in  in  Q  input real part.
- data_i_in  in  Q  input imaginary part.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts sample.
- data_r_out  out  Q  output real part.
- data_i_out  out  Q  output imaginary part.
- out_last  out  1  marks the final sample of the symbol.
- out_idx  out  log2N  natural-order index of the sample currently on the output.

Behaviour:
- Reset values: state FILL, wr_cnt=0, rd_cnt=0, out_valid=0, data_r_out=0, data_i_out=0, out_last=0, out_idx=0.
- Memory contents are not reset.
- in_ready = (state==FILL); it is combinational from the state register.
- in_fire = in_valid & in_ready. On in_fire, mem[wr_cnt] <= {data_r_in, data_i_in} and wr_cnt increments.
- When in_fire occurs with wr_cnt==N-1: wr_cnt wraps to 0 and state -> DRAIN on the next edge.
- DRAIN, load condition: load = (state==DRAIN) & rd_pend & (!out_valid | out_ready).
  - rd_pend is 1 while fewer than N samples have been loaded this symbol.
  - On load, the output registers take mem[bitrev(rd_cnt)], out_idx <= bitrev(rd_cnt), out_last <= (rd_cnt==N-1), out_valid <= 1, and rd_cnt increments.
  - Memory read latency is 1 cycle, registered output.
- If !load and out_ready, out_valid <= 0.
- While out_valid & !out_ready, all output registers hold their values.
- Latency: the final input write lands at edge k and the first sample is valid after edge k+2.
- With out_ready held at 1, throughput is 1 sample/cycle with no bubbles.
- On the out_fire of the sample with out_last=1: state -> FILL, rd_cnt=0, and out_valid drops unless another load occurs (none is possible in FILL). in_ready rises the cycle after that fire.
- No input is accepted during DRAIN; upstream stalls via in_ready=0.
- bitrev(i) reverses the log2N address bits, e.g. for N=64: 1->32, 2->16, 3->48, 63->63.
- Reset asserted mid-FILL or mid-DRAIN aborts the symbol immediately. Outputs and counters go to their reset values, and any partial symbol is discarded.
- in_valid with X data while in_ready=0 is ignored.

Optional Feature:
- Macro: FFT_BITREV_BUF_BITREV_EN.
- Defined: readout in bit-reversed order, as described above.
- Undefined: readout in natural order, i.e. the read address and out_idx equal rd_cnt. Handshake, latency and out_last are unchanged. This mode serves a DIF FFT, which takes natural-order input.

Decomposition:
- Shared package ofdm_rx_pkg holds:
  - Constants FFT_LOG2N=6, FFT_N=64, SAMPLE_Q=16.
  - A cplx_t typedef (struct of r,i, Q bits each).
  - A bitrev function parameterised on width.
- One natural sub-module: fft_buf_ram, a simple dual-port N x 2Q RAM with one write port, one synchronous read port and a read enable. It is instantiated once.
- The FSM, counters and output register live in the top level.

Test Plan:
- Fill then drain, out_ready=1: write data_r=i, data_i=-i for i=0..63.
  - Outputs follow order 0,32,16,48,8,40,...,63.
  - out_last is asserted only on idx 63.
  - First out_valid comes 2 cycles after the last write, followed by 64 consecutive valid cycles.
- Backpressure: toggle out_ready with a random 50% pattern during drain. The output holds stable while stalled, no sample is lost or duplicated, and the order is identical to the first test.
- Input gaps and blocking:
  - Drive in_valid with gaps; exactly 64 accepts occur before in_ready falls.
  - in_valid held high during DRAIN writes nothing; compare memory afterward.
- Back-to-back symbols: symbol A values 0x0100+i, symbol B values 0x0200+i.
  - in_ready rises 1 cycle after A's out_last fire.
  - B is output fully bit-reversed with no A values mixed in.
- Reset mid-DRAIN: assert rst_n after 10 outputs.
  - out_valid=0 and in_ready=1 after release.
  - A fresh symbol then drains correctly from index 0.
- Macro undefined: same stimulus as the first test yields outputs 0,1,2,...,63 with out_idx==data_r_out.

Source files
------------

// File: rtl/ofdm_rx_pkg.sv
// Shared receiver definitions: FFT sizing, complex sample type, bit-reversal helper
// and the state encoding of the FFT input reorder buffer.
package ofdm_rx_pkg;

  localparam int FFT_LOG2N = 6;
  localparam int FFT_N     = 64;
  localparam int SAMPLE_Q  = 16;

  typedef struct packed {
    logic signed [SAMPLE_Q-1:0] r;
    logic signed [SAMPLE_Q-1:0] i;
  } cplx_t;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } buf_state_t;

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 32; b++) begin
      if (b < w) r[b] = v[w-1-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_buf_ram.sv
// Simple dual-port RAM: one write port and one registered, enable-gated read port.
// Contents are never reset.
module fft_buf_ram #(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];

  // rd_data holds its value while rd_en is low, so it doubles as a pipeline stage.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fft_bitrev_buf.sv
// Single-bank FFT input reorder buffer: fills one symbol in natural order, then drains it.
// Define FFT_BITREV_BUF_BITREV_EN for bit-reversed readout; otherwise readout is natural order.
module fft_bitrev_buf
  import ofdm_rx_pkg::*;
#(
  parameter int LOG2N = FFT_LOG2N,
  parameter int Q     = SAMPLE_Q,
  parameter int N     = FFT_N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Q-1:0]     data_r_in,
  input  logic [Q-1:0]     data_i_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Q-1:0]     data_r_out,
  output logic [Q-1:0]     data_i_out,
  output logic             out_last,
  output logic [LOG2N-1:0] out_idx
);

  buf_state_t       state_reg, state_next;
  logic [LOG2N-1:0] wr_cnt_reg;
  logic [LOG2N:0]   rd_cnt_reg;
  logic             s1_valid_reg;
  logic [LOG2N-1:0] s1_idx_reg;
  logic             s1_last_reg;

  logic             in_fire, out_fire, out_adv, rd_pend, rd_issue;
  logic [LOG2N-1:0] rd_lo, rd_addr;
  logic [2*Q-1:0]   ram_q;

  assign rd_lo = rd_cnt_reg[LOG2N-1:0];

`ifdef FFT_BITREV_BUF_BITREV_EN
  assign rd_addr = LOG2N'(bitrev(32'(rd_lo), LOG2N));
`else
  assign rd_addr = rd_lo;
`endif

  // Stage 1 is the RAM read register; the output registers form stage 2.
  always_comb begin
    in_ready   = (state_reg == ST_FILL);
    in_fire    = in_valid & in_ready;
    out_fire   = out_valid & out_ready;
    out_adv    = s1_valid_reg & (!out_valid | out_ready);
    rd_pend    = !rd_cnt_reg[LOG2N];
    rd_issue   = (state_reg == ST_DRAIN) & rd_pend & (!s1_valid_reg | out_adv);
    state_next = state_reg;
    case (state_reg)
      ST_FILL:  if (in_fire && wr_cnt_reg == LOG2N'(N-1)) state_next = ST_DRAIN;
      ST_DRAIN: if (out_fire && out_last) state_next = ST_FILL;
      default:  state_next = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_reg <= ST_FILL;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_cnt_reg   <= '0;
      rd_cnt_reg   <= '0;
      s1_valid_reg <= 1'b0;
      s1_idx_reg   <= '0;
      s1_last_reg  <= 1'b0;
      out_valid    <= 1'b0;
      data_r_out   <= '0;
      data_i_out   <= '0;
      out_last     <= 1'b0;
      out_idx      <= '0;
    end else begin
      if (in_fire) wr_cnt_reg <= wr_cnt_reg + 1'b1;

      if (state_reg == ST_DRAIN && out_fire && out_last) begin
        rd_cnt_reg <= '0;
      end else if (rd_issue) begin
        rd_cnt_reg <= rd_cnt_reg + 1'b1;
      end

      if (rd_issue) begin
        s1_valid_reg <= 1'b1;
        s1_idx_reg   <= rd_addr;
        s1_last_reg  <= (rd_lo == LOG2N'(N-1));
      end else if (out_adv) begin
        s1_valid_reg <= 1'b0;
      end

      // Output registers hold whenever a valid sample is stalled by out_ready.
      if (out_adv) begin
        out_valid  <= 1'b1;
        data_r_out <= ram_q[2*Q-1:Q];
        data_i_out <= ram_q[Q-1:0];
        out_idx    <= s1_idx_reg;
        out_last   <= s1_last_reg;
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end
    end
  end

  fft_buf_ram #(
    .AW(LOG2N),
    .DW(2*Q)
  ) u_ram (
    .clk    (clk),
    .wr_en  (in_fire),
    .wr_addr(wr_cnt_reg),
    .wr_data({data_r_in, data_i_in}),
    .rd_en  (rd_issue),
    .rd_addr(rd_addr),
    .rd_data(ram_q)
  );

endmodule

// File: tb/tb_fft_bitrev_buf.sv
// Directed bench for fft_bitrev_buf; expected order follows FFT_BITREV_BUF_BITREV_EN.
module tb_fft_bitrev_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] data_r_in, data_i_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] data_r_out, data_i_out;
  logic        out_last;
  logic [5:0]  out_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fft_bitrev_buf dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_r_in (data_r_in),
    .data_i_in (data_i_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_r_out(data_r_out),
    .data_i_out(data_i_out),
    .out_last  (out_last),
    .out_idx   (out_idx)
  );

  function automatic int rev6(input int v);
    int r = 0;
    for (int b = 0; b < 6; b++) r = (r << 1) | ((v >> b) & 1);
    return r;
  endfunction

  function automatic int exp_addr(input int k);
`ifdef FFT_BITREV_BUF_BITREV_EN
    return rev6(k);
`else
    return k;
`endif
  endfunction

  // Drives 64 accepted samples; returns at the negedge whose following posedge takes the last one.
  task automatic fill(input int rbase, input int ibase, input bit neg, input bit gaps);
    int acc = 0;
    int guard = 0;
    while (acc < 64 && guard < 1000) begin
      @(negedge clk);
      guard++;
      in_valid  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      data_r_in = 16'(rbase + acc);
      data_i_in = neg ? 16'(-acc) : 16'(ibase + acc);
      if (in_valid && in_ready) acc++;
    end
    checks++;
    if (acc != 64) begin
      errors++;
      $display("FAIL fill_accepts: got %0d required 64", acc);
    end
  endtask

  // Consumes stop_after output samples, checking order, data, last flag, stalls and latency.
  task automatic drain(input int rbase, input int ibase, input bit neg, input bit rand_ready,
                       input bit hold_in, input int stop_after, input int exp_lat);
    int got = 0, cyc = 0, lat = -1, a;
    bit stalled = 0;
    logic [15:0] pr, pi, er, ei;
    logic [5:0]  pidx;
    logic        plast;
    while (got < stop_after && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL drain_in_ready: got %b required 0", in_ready);
      end
      if (out_valid === 1'b1 && lat < 0) lat = cyc;
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || data_r_out !== pr || data_i_out !== pi ||
            out_idx !== pidx || out_last !== plast) begin
          errors++;
          $display("FAIL stall_hold: got v=%b r=%h i=%h idx=%0d required v=1 r=%h i=%h idx=%0d",
                   out_valid, data_r_out, data_i_out, out_idx, pr, pi, pidx);
        end
      end
      if (!rand_ready && got > 0 && got < 64) begin
        checks++;
        if (out_valid !== 1'b1) begin
          errors++;
          $display("FAIL no_bubble: got out_valid=%b at sample %0d required 1", out_valid, got);
        end
      end
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = hold_in;
      data_r_in = 16'hDEAD;
      data_i_in = 16'hBEEF;
      stalled   = 0;
      if (out_valid === 1'b1) begin
        if (out_ready) begin
          a  = exp_addr(got);
          er = 16'(rbase + a);
          ei = neg ? 16'(-a) : 16'(ibase + a);
          checks++;
          if (data_r_out !== er || data_i_out !== ei || out_idx !== 6'(a) ||
              out_last !== (got == 63)) begin
            errors++;
            $display("FAIL sample_%0d: got r=%h i=%h idx=%0d last=%b required r=%h i=%h idx=%0d last=%b",
                     got, data_r_out, data_i_out, out_idx, out_last, er, ei, a, (got == 63));
          end
          got++;
        end else begin
          stalled = 1;
          pr = data_r_out; pi = data_i_out; pidx = out_idx; plast = out_last;
        end
      end
    end
    checks++;
    if (got != stop_after) begin
      errors++;
      $display("FAIL drain_count: got %0d required %0d", got, stop_after);
    end
    if (exp_lat > 0) begin
      checks++;
      if (lat != exp_lat) begin
        errors++;
        $display("FAIL first_valid_latency: got %0d required %0d", lat, exp_lat);
      end
    end
    $display("drain: %0d samples, first valid at cycle %0d", got, lat);
  endtask

  // Checks the cycle after the final out_last fire: back in FILL, output idle.
  task automatic check_after_drain(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_refill: got in_ready=%b out_valid=%b required 1 0", tag, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    data_r_in = '0; data_i_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || data_r_out !== 16'h0 ||
        data_i_out !== 16'h0 || out_last !== 1'b0 || out_idx !== 6'd0) begin
      errors++;
      $display("FAIL reset_state: got v=%b rdy=%b r=%h i=%h last=%b idx=%0d required 0 1 0 0 0 0",
               out_valid, in_ready, data_r_out, data_i_out, out_last, out_idx);
    end
    $display("test_reset done");
  endtask

  task automatic test_fill_drain();
    fill(0, 0, 1'b1, 1'b0);
    drain(0, 0, 1'b1, 1'b0, 1'b0, 64, 3);
    check_after_drain("fill_drain");
  endtask

  task automatic test_backpressure();
    fill(0, 0, 1'b1, 1'b0);
    drain(0, 0, 1'b1, 1'b1, 1'b1, 64, 0);
    check_after_drain("backpressure");
  endtask

  task automatic test_input_gaps();
    fill(16'h3000, 16'h4000, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL gaps_ready_fall: got %b required 0", in_ready);
    end
    // First drain cycle already elapsed above; latency is not rechecked here.
    drain(16'h3000, 16'h4000, 1'b0, 1'b0, 1'b1, 64, 0);
    check_after_drain("gaps");
  endtask

  task automatic test_back_to_back();
    fill(16'h0100, 16'h1100, 1'b0, 1'b0);
    drain(16'h0100, 16'h1100, 1'b0, 1'b1, 1'b0, 64, 0);
    check_after_drain("symbol_a");
    fill(16'h0200, 16'h1200, 1'b0, 1'b0);
    drain(16'h0200, 16'h1200, 1'b0, 1'b0, 1'b0, 64, 3);
    check_after_drain("symbol_b");
  endtask

  task automatic test_reset_mid_drain();
    fill(16'h0500, 16'h0600, 1'b0, 1'b0);
    drain(16'h0500, 16'h0600, 1'b0, 1'b0, 1'b0, 10, 0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_idx !== 6'd0) begin
      errors++;
      $display("FAIL mid_drain_reset: got v=%b rdy=%b idx=%0d required 0 1 0",
               out_valid, in_ready, out_idx);
    end
    fill(16'h0700, 16'h0800, 1'b0, 1'b0);
    drain(16'h0700, 16'h0800, 1'b0, 1'b0, 1'b0, 64, 3);
    check_after_drain("post_reset");
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_backpressure();
    test_input_gaps();
    test_back_to_back();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
